// File: rtl/pipe_pkg.sv
// pipe_pkg: shared MEM/WB entry layout and write-back select encodings.
package pipe_pkg;
  localparam int PKG_DATA_W = 32;
  localparam int PKG_REG_AW = 5;
  localparam logic WB_SEL_MEM = 1'b1;
  localparam logic WB_SEL_ALU = 1'b0;
  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
    logic [PKG_DATA_W-1:0] mem_data;
    logic [PKG_DATA_W-1:0] alu_result;
    logic [PKG_REG_AW-1:0] write_reg;
  } mem_wb_entry_t;
endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: valid/ready buffer with flush, two entries (registered ready) or one (combinational ready).
module pipe_skid_buf #(
  parameter int W = 8,
  parameter bit SKID = 1'b1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         inValid,
  output logic         inReady,
  input  logic [W-1:0] inData,
  output logic         outValid,
  input  logic         outReady,
  output logic [W-1:0] outData
);
  logic mainValid;
  logic [W-1:0] mainData;
  logic accept, consume;
  assign outValid = mainValid;
  assign outData = mainData;
  assign accept = inValid && inReady;
  assign consume = mainValid && outReady;
  if (SKID) begin : g_skid
    logic skidValid;
    logic [W-1:0] skidData;
    // Ready depends only on registered skid state, so it never combinationally follows outReady.
    assign inReady = !skidValid && !flush;
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        mainValid <= 1'b0;
        skidValid <= 1'b0;
        mainData <= '0;
        skidData <= '0;
      end else if (flush) begin
        mainValid <= 1'b0;
        skidValid <= 1'b0;
      end else if (accept && mainValid && !consume) begin
        skidData <= inData;
        skidValid <= 1'b1;
      end else if (accept) begin
        mainData <= inData;
        mainValid <= 1'b1;
      end else if (consume) begin
        if (skidValid) mainData <= skidData;
        mainValid <= skidValid;
        skidValid <= 1'b0;
      end
    end
  end else begin : g_single
    assign inReady = (!mainValid || outReady) && !flush;
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        mainValid <= 1'b0;
        mainData <= '0;
      end else if (flush) begin
        mainValid <= 1'b0;
      end else if (accept) begin
        mainData <= inData;
        mainValid <= 1'b1;
      end else if (consume) begin
        mainValid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/mem_wb_pipe_stage.sv
// mem_wb_pipe_stage: MEM->WB stage with flow control, flush, register-0 guard, WB mux and retire counter.
module mem_wb_pipe_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = PKG_DATA_W,
  parameter int REG_AW = PKG_REG_AW,
  parameter bit SKID = 1'b1,
  parameter bit ZERO_GUARD = 1'b1,
  parameter int CNT_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mem_to_reg,
  input  logic              in_reg_write,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [REG_AW-1:0] in_write_reg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_reg_write,
  output logic [REG_AW-1:0] out_write_reg,
  output logic [DATA_W-1:0] out_wb_data,
  output logic              out_mem_to_reg,
  output logic [CNT_W-1:0]  retire_count
);
  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] alu_result;
    logic [REG_AW-1:0] write_reg;
  } entry_t;
  entry_t inEntry, head;
  assign inEntry = '{mem_to_reg: in_mem_to_reg, reg_write: in_reg_write, mem_data: in_mem_data,
                     alu_result: in_alu_result, write_reg: in_write_reg};
  pipe_skid_buf #(.W($bits(entry_t)), .SKID(SKID)) skidBuf (
    .clock(clock),
    .reset_n(reset_n),
    .flush(flush),
    .inValid(in_valid),
    .inReady(in_ready),
    .inData(inEntry),
    .outValid(out_valid),
    .outReady(out_ready),
    .outData(head)
  );
  assign out_reg_write = out_valid && head.reg_write && !(ZERO_GUARD && head.write_reg == '0);
  assign out_write_reg = head.write_reg;
  assign out_mem_to_reg = head.mem_to_reg;
  assign out_wb_data = (head.mem_to_reg == WB_SEL_MEM) ? head.mem_data : head.alu_result;
  always_ff @(posedge clock) begin
    if (!reset_n) retire_count <= '0;
    else if (out_valid && out_ready && out_reg_write) retire_count <= retire_count + 1'b1;
  end
endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// tb_mem_wb_pipe_stage: queue-model checked random and directed stimulus for the MEM/WB stage.
module tb_mem_wb_pipe_stage;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;
  logic clock = 0, reset_n = 0, flush = 0, in_valid = 0, in_mem_to_reg = 0, in_reg_write = 0, out_ready = 0;
  logic [DW-1:0] in_mem_data = 0, in_alu_result = 0;
  logic [AW-1:0] in_write_reg = 0;
  logic in_ready, out_valid, out_reg_write, out_mem_to_reg;
  logic [AW-1:0] out_write_reg;
  logic [DW-1:0] out_wb_data;
  logic [CW-1:0] retire_count;
  mem_wb_pipe_stage #(.DATA_W(DW), .REG_AW(AW), .SKID(1'b1), .ZERO_GUARD(1'b1), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write), .in_mem_data(in_mem_data),
    .in_alu_result(in_alu_result), .in_write_reg(in_write_reg), .out_valid(out_valid),
    .out_ready(out_ready), .out_reg_write(out_reg_write), .out_write_reg(out_write_reg),
    .out_wb_data(out_wb_data), .out_mem_to_reg(out_mem_to_reg), .retire_count(retire_count)
  );
  always #5 clock = ~clock;
  typedef struct {
    logic m2r;
    logic rw;
    logic [DW-1:0] mem;
    logic [DW-1:0] alu;
    logic [AW-1:0] wr;
  } ent_t;
  ent_t q[$];
  int mCount = 0;
  bit mAcc = 0;
  bit chkOn = 0;
  int checks = 0, errors = 0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: a FIFO of at most two entries; flush empties it, reset empties it and clears the count.
  always @(posedge clock) begin
    bit rdy, cons;
    if (!reset_n) begin
      q.delete();
      mCount = 0;
      mAcc = 0;
    end else begin
      rdy = q.size() < 2 && !flush;
      mAcc = in_valid && rdy;
      cons = q.size() > 0 && out_ready;
      if (cons && q[0].rw && q[0].wr != 0) mCount = (mCount + 1) % (1 << CW);
      if (flush) q.delete();
      else begin
        if (cons) void'(q.pop_front());
        if (mAcc) q.push_back('{in_mem_to_reg, in_reg_write, in_mem_data, in_alu_result, in_write_reg});
      end
    end
  end
  always @(negedge clock) begin
    ent_t h;
    if (chkOn) begin
      chk("in_ready", in_ready, q.size() < 2 && !flush);
      chk("out_valid", out_valid, q.size() > 0);
      chk("retire_count", retire_count, mCount);
      if (q.size() > 0) begin
        h = q[0];
        chk("out_reg_write", out_reg_write, h.rw && h.wr != 0);
        chk("out_wb_data", out_wb_data, h.m2r ? h.mem : h.alu);
        chk("out_write_reg", out_write_reg, h.wr);
        chk("out_mem_to_reg", out_mem_to_reg, h.m2r);
      end else chk("out_reg_write_idle", out_reg_write, 0);
    end
  end
  task automatic put(logic v, logic m2r, logic rw, logic [DW-1:0] mem, logic [DW-1:0] alu, logic [AW-1:0] wr);
    in_valid = v;
    in_mem_to_reg = m2r;
    in_reg_write = rw;
    in_mem_data = mem;
    in_alu_result = alu;
    in_write_reg = wr;
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  initial begin
    reset_n = 0;
    put(1, 0, 1, 'h55, 'h66, 3);
    tick;
    chkOn = 1;
    repeat (2) tick;
    reset_n = 1;
    put(0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", retire_count, 0);
    chk("rst_wb_data", out_wb_data, 0);
    chk("rst_write_reg", out_write_reg, 0);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      put(1, 0, 1, 0, 'h10 + i, AW'(i + 1));
      tick;
      chk("stream_wb", out_wb_data, 'h10 + i);
      chk("stream_wr", out_write_reg, i + 1);
    end
    put(0, 0, 0, 0, 0, 0);
    tick;
    chk("stream_count", retire_count, 4);
    out_ready = 0;
    put(1, 0, 1, 0, 'hA, 5);
    tick;
    put(1, 0, 1, 0, 'hB, 6);
    tick;
    put(1, 0, 1, 0, 'hC, 7);
    #1;
    chk("stall_ready", in_ready, 0);
    chk("stall_head", out_wb_data, 'hA);
    out_ready = 1;
    tick;
    chk("drain_b", out_wb_data, 'hB);
    tick;
    chk("drain_c", out_wb_data, 'hC);
    put(0, 0, 0, 0, 0, 0);
    tick;
    out_ready = 0;
    put(1, 0, 1, 0, 'hD, 8);
    tick;
    put(1, 0, 1, 0, 'hE, 9);
    tick;
    flush = 1;
    put(1, 0, 1, 0, 'hF, 10);
    #1;
    chk("flush_ready", in_ready, 0);
    tick;
    flush = 0;
    put(0, 0, 0, 0, 0, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_count", retire_count, 7);
    put(1, 1, 1, 'hDEAD, 'h1234, 0);
    tick;
    put(0, 0, 0, 0, 0, 0);
    chk("zg_reg_write", out_reg_write, 0);
    chk("zg_wb_data", out_wb_data, 'hDEAD);
    chk("zg_valid", out_valid, 1);
    out_ready = 1;
    tick;
    chk("zg_count", retire_count, 7);
    for (int c = 0; c < 600; c++) begin
      if (!(in_valid && !mAcc))
        put($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), $urandom, $urandom, AW'($urandom_range(0, 7)));
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 19) == 0;
      reset_n = $urandom_range(0, 99) != 0;
      tick;
    end
    flush = 0;
    reset_n = 0;
    put(0, 0, 0, 0, 0, 0);
    tick;
    reset_n = 1;
    out_ready = 1;
    for (int i = 0; i < 17; i++) begin
      put(1, 0, 1, 0, i, AW'(1 + i % 31));
      tick;
    end
    put(0, 0, 0, 0, 0, 0);
    repeat (2) tick;
    chk("wrap_count", retire_count, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
